// File: rtl/sri_deserializer.sv
// STI serial-to-parallel receiver: rebuilds 8/16/24/32-bit words into a 2-entry ready/valid buffer.
// Word visible on po_valid the cycle after its last bit; a word completing into a full buffer is dropped (sticky overflow).

module sri_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld_i,
  input  logic [W-1:0] push_dat_i,
  output logic         push_rdy_o,
  output logic         pop_vld_o,
  output logic [W-1:0] pop_dat_o,
  input  logic         pop_rdy_i
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          push_fire;
  logic          pop_fire;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_vld_o  = (cnt_q != '0);
  assign pop_fire   = pop_vld_o & pop_rdy_i;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push_rdy_o = (cnt_q != CW'(DEPTH)) | pop_fire;
  assign push_fire  = push_vld_i & push_rdy_o;
  assign pop_dat_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_fire) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop_fire) rd_q <= ptr_inc(rd_q);
      case ({push_fire, pop_fire})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module sri_deserializer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_msb,
  input  logic        si_valid,
  input  logic        si_data,
  input  logic        si_end,
  input  logic        po_ready,
  output logic        po_valid,
  output logic [31:0] po_data,
  output logic        overflow,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    ENDED = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [1:0]  len_q;
  logic        msb_q;
  logic        end_seen_q;
  logic [31:0] sr_q;
  logic [31:0] sr_d;
  logic        overflow_q;

  logic [1:0]  cur_len;
  logic        cur_msb;
  logic [4:0]  last_idx;
  logic [31:0] sr_base;
  logic        take;
  logic        word_done;
  logic        push_rdy;

  // The first bit of a word uses the live config pins; later bits use the latched copy.
  assign cur_len  = (state_q == IDLE) ? cfg_length : len_q;
  assign cur_msb  = (state_q == IDLE) ? cfg_msb    : msb_q;
  assign last_idx = {cur_len, 3'b111};
  assign sr_base  = (state_q == IDLE) ? 32'd0 : sr_q;

  assign take = si_valid & (((state_q == IDLE) & ~si_end) | (state_q == RECV));
  assign word_done = take & (state_q == RECV) & (cnt_q == last_idx);

  always_comb begin
    sr_d = sr_base;
    if (cur_msb) begin
      sr_d = {sr_base[30:0], si_data};
    end else begin
      sr_d[cnt_q] = si_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      msb_q      <= 1'b0;
      end_seen_q <= 1'b0;
      sr_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (si_end) begin
            state_q <= ENDED;
          end else if (si_valid) begin
            len_q   <= cfg_length;
            msb_q   <= cfg_msb;
            sr_q    <= sr_d;
            cnt_q   <= 5'd1;
            state_q <= RECV;
          end
        end
        RECV: begin
          if (si_end) end_seen_q <= 1'b1;
          if (si_valid) begin
            sr_q <= sr_d;
            if (word_done) begin
              cnt_q   <= '0;
              state_q <= (end_seen_q | si_end) ? ENDED : IDLE;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        ENDED: state_q <= ENDED;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (word_done & ~push_rdy) begin
      overflow_q <= 1'b1;
    end
  end

  sri_fifo #(
    .DEPTH(DEPTH),
    .W    (32)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push_vld_i(word_done),
    .push_dat_i(sr_d),
    .push_rdy_o(push_rdy),
    .pop_vld_o (po_valid),
    .pop_dat_o (po_data),
    .pop_rdy_i (po_ready)
  );

  assign overflow = overflow_q;
  assign busy     = (state_q == RECV);
  // No word can be pushed once ENDED is reached, so an empty buffer there stays empty.
  assign done     = (state_q == ENDED) & ~po_valid;
endmodule

// File: tb/tb_sri_deserializer.sv
// Randomised scoreboard bench for sri_deserializer: words are serialised from values, expected
// words queued by a buffer-level model, and a negedge monitor compares every DUT output.
module tb_sri_deserializer;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic        si_valid;
  logic        si_data;
  logic        si_end;
  wire         po_ready;
  logic        po_valid;
  logic [31:0] po_data;
  logic        overflow;
  logic        busy;
  logic        done;

  logic [1:0]  rdy_mode;   // 0 = hold low, 1 = hold high, 2 = random
  logic        rnd_rdy = 1'b0;
  assign po_ready = (rdy_mode == 2'd2) ? rnd_rdy : rdy_mode[0];

  sri_deserializer #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_length(cfg_length),
    .cfg_msb   (cfg_msb),
    .si_valid  (si_valid),
    .si_data   (si_data),
    .si_end    (si_end),
    .po_ready  (po_ready),
    .po_valid  (po_valid),
    .po_data   (po_data),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd_rdy = 1'($urandom_range(1));
  end

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: buffer of accepted words plus word/stream status.
  logic [31:0] exp_q[$];
  logic        last_bit;
  logic [31:0] cur_exp;
  bit          mid, pend, ended, exp_ovf;
  bit          m_pop, m_room;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      mid = 0; pend = 0; ended = 0; exp_ovf = 0;
    end else begin
      m_pop  = (exp_q.size() > 0) && po_ready;
      m_room = (exp_q.size() < 2) || m_pop;
      if (m_pop) void'(exp_q.pop_front());
      if (!ended) begin
        if (si_end && !mid) begin
          ended = 1;
        end else begin
          if (si_end) pend = 1;
          if (si_valid) begin
            if (last_bit) begin
              if (m_room) exp_q.push_back(cur_exp);
              else exp_ovf = 1;
              mid = 0;
              if (pend) ended = 1;
            end else begin
              mid = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    check("po_valid", 32'(po_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("po_data", po_data, exp_q[0]);
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("busy", 32'(busy), 32'(mid));
    check("done", 32'(done), 32'(ended && exp_q.size() == 0));
  end

  // Serialise w as an 8*(len+1)-bit word. gap_mode: 0 none, 1 alternate, 2 random.
  // chg_at: bit index before which cfg_length is switched to 8 bits; end_at: bit carrying si_end;
  // stop_at: abandon the word after this many bits (-1 = complete it).
  task automatic send_word(input int len, input bit msb, input logic [31:0] w,
                           input int gap_mode, input int chg_at, input int end_at,
                           input int stop_at);
    int n;
    logic [63:0] m;
    n = 8 * (len + 1);
    m = (64'd1 << n) - 64'd1;
    cur_exp    = w & m[31:0];
    cfg_length = 2'(len);
    cfg_msb    = msb;
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) break;
      if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(3) == 0)) begin
        si_valid = 0; si_end = 0; last_bit = 0;
        @(posedge clk); #1;
      end
      if (i == chg_at) cfg_length = 2'b00;
      si_valid = 1;
      si_data  = msb ? w[n-1-i] : w[i];
      si_end   = (i == end_at);
      last_bit = (i == n - 1);
      @(posedge clk); #1;
    end
    si_valid = 0; si_end = 0; last_bit = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; cfg_length = 0; cfg_msb = 0; si_valid = 0; si_data = 0; si_end = 0;
    last_bit = 0; cur_exp = 0; rdy_mode = 2'd1;
    #2;
    check("rst_po_valid", 32'(po_valid), 0);
    check("rst_po_data", po_data, 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // MSB-first 8-bit 0xA5
    send_word(0, 1, 32'hA5, 0, -1, -1, -1);
    repeat (3) @(posedge clk); #1;

    // LSB-first 16-bit 0x1234 with alternating gaps
    send_word(1, 0, 32'h1234, 1, -1, -1, -1);
    repeat (3) @(posedge clk); #1;

    // 32-bit back-to-back
    send_word(3, 1, 32'hDEADBEEF, 0, -1, -1, -1);
    send_word(3, 1, 32'h0F0F0F0F, 0, -1, -1, -1);
    repeat (4) @(posedge clk); #1;

    // Overflow: third word dropped while downstream stalls
    rdy_mode = 2'd0;
    send_word(0, 1, 32'h11, 0, -1, -1, -1);
    send_word(0, 1, 32'h22, 0, -1, -1, -1);
    send_word(0, 1, 32'h33, 0, -1, -1, -1);
    check("ovf_set", 32'(overflow), 1);
    check("ovf_head", po_data, 32'h11);
    rdy_mode = 2'd1;
    repeat (4) @(posedge clk); #1;
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_drained", 32'(po_valid), 0);

    // Mid-word config change and si_end, then ignored bits
    do_reset();
    send_word(2, 1, 32'hABCDEF, 0, 6, 10, -1);
    send_word(0, 1, 32'h5A, 0, -1, -1, -1);
    repeat (3) @(posedge clk); #1;
    check("end_done", 32'(done), 1);
    check("end_busy", 32'(busy), 0);

    // Asynchronous reset after 4 bits of an 8-bit word
    do_reset();
    send_word(0, 1, 32'hC3, 0, -1, -1, 4);
    check("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_po_valid", 32'(po_valid), 0);
    check("arst_po_data", po_data, 0);
    check("arst_overflow", 32'(overflow), 0);
    check("arst_done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 0;
    send_word(0, 1, 32'h3C, 0, -1, -1, -1);
    check("post_rst_word", po_data, 32'h3C);
    repeat (3) @(posedge clk); #1;

    // Random words, random gaps, random downstream backpressure
    do_reset();
    rdy_mode = 2'd2;
    for (int k = 0; k < 150; k++) begin
      send_word(int'($urandom_range(3)), 1'($urandom_range(1)), $urandom, 2, -1, -1, -1);
    end
    rdy_mode = 2'd1;
    repeat (5) @(posedge clk); #1;
    check("rand_drained", 32'(po_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sri_deserializer.md
# sri_deserializer

Serial-to-parallel receiver for the STI serial link. It accepts the `so_valid`/`so_data` bit stream produced by the STI transmitter and rebuilds 8/16/24/32-bit words. Each completed word is handed to the downstream DAC/memory writer through a 2-entry ready/valid output buffer. Word length and bit order are programmed by the same configuration pins that drive the transmitter.

## Interface
Parameters:
- DEPTH, 2, output buffer depth in words; fixed at 2 for this block.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- cfg_length  in  2  word length: 00=8, 01=16, 10=24, 11=32 bits.
- cfg_msb  in  1  1 = first received bit is word MSB; 0 = first bit is LSB.
- si_valid  in  1  serial bit qualifier; connects to transmitter `so_valid`.
- si_data  in  1  serial bit; sampled only when si_valid=1.
- si_end  in  1  end-of-stream pulse; no new word may start after it.
- po_ready  in  1  downstream accepts the head word this cycle.
- po_valid  out  1  buffer non-empty; head word on po_data.
- po_data  out  32  received word, right-aligned, unused upper bits 0.
- overflow  out  1  sticky: a completed word was dropped because the buffer was full.
- busy  out  1  a word is partially received (bit counter ≠ 0).
- done  out  1  sticky: si_end seen and the receiver is idle with an empty buffer.

## Operation
- States:
  - IDLE: bit count 0. If si_valid=1, latch cfg_length/cfg_msb into len_q/msb_q, take bit 0 and go to RECV.
  - RECV: each si_valid=1 cycle takes one bit. On bit N-1 (N = 8·(len_q+1)), push the word and return to IDLE.
  - ENDED: entered from IDLE when si_end=1, or from RECV at word completion if si_end was seen earlier. ENDED ignores si_valid; only rst leaves it.
- Configuration is sampled only on the first bit of a word. Changes mid-word do not affect the word in progress.
- si_valid=0 cycles inside a word are gaps: no bit is taken and the counter holds.
- Assembly, bit index i = 0..N-1:
  - msb_q=1: shift register `sr <= {sr[30:0], si_data}`, so the first bit lands at position N-1.
  - msb_q=0: `sr[i] <= si_data`, so the first bit lands at position 0.
  - sr is cleared to 0 at word start; bits ≥ N are always 0.
- Push on completion:
  - If the buffer holds fewer than 2 words, or holds 2 and a pop occurs in the same cycle, write the word.
  - Otherwise drop the word and set overflow=1. Overflow stays set until rst.
- Pop: po_valid & po_ready removes the head word. po_ready while po_valid=0 has no effect.
- Simultaneous push and pop on a 1-entry buffer: occupancy stays 1, and the new word becomes head after the pop.
- si_end during RECV: the current word completes normally, then the block enters ENDED. done=1 once ENDED is reached and the buffer is empty.
- busy = (state==RECV).

## Timing
- Reset (async, immediate): state=IDLE, counter=0, sr=0, buffer empty, po_valid=0, po_data=0, overflow=0, busy=0, done=0.
- Latency: last bit of a word sampled at edge k → po_valid=1 and po_data valid from edge k (visible in cycle k+1), if the buffer was empty.
- Minimum word period: N cycles with no gaps. Back-to-back words need no idle cycle; the bit after the last bit is bit 0 of the next word.
- po_data is the buffer head and stays stable while po_valid=1 and po_ready=0.
- Reset asserted mid-word: the partial word is discarded; bits after reset release start a new word.
- Counter width 5 bits. It returns to 0 on completion and never wraps past N-1.

## Test plan
- MSB-first 8-bit: cfg_length=00, cfg_msb=1, bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles, po_ready=1 → po_valid one cycle after the 8th bit, po_data=0x000000A5.
- LSB-first 16-bit with gaps: cfg_length=01, cfg_msb=0, serialise 0x1234 LSB first with si_valid low every other cycle → po_data=0x00001234; busy=1 throughout reception.
- 32-bit back-to-back: cfg_length=11, cfg_msb=1, send 0xDEADBEEF then 0x0F0F0F0F with no gap, po_ready=1 → two pops, correct values in order, no overflow.
- Overflow: po_ready=0, send three 8-bit words 0x11, 0x22, 0x33 → buffer holds 0x11 and 0x22, overflow=1 after the third word. Then po_ready=1 → pops 0x11, then 0x22; overflow stays 1.
- Config change mid-word plus si_end: start a 24-bit MSB-first word 0xABCDEF, switch cfg_length to 00 after bit 5, pulse si_end at bit 10 → po_data=0x00ABCDEF. The block enters ENDED, further si_valid bits are ignored, and done=1 after the pop.
- Async reset mid-word: assert rst after 4 bits of an 8-bit word → all outputs 0 immediately. After release, the next 8 bits yield exactly one correct word.
